// File: rtl/booth_mac_pkg.sv
// ============================================================================
// Module  : booth_mac_pkg
// Purpose : Shared state encoding, default widths and accumulator limit
//           functions for booth_product_accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int LEN_W_DEF  = 8;
  localparam int ACC_W_LIM  = 128;

  // Callers truncate the result to acc_w bits; the low acc_w bits hold the limit.
  function automatic logic [ACC_W_LIM-1:0] ACC_MAX(input int acc_w);
    return (ACC_W_LIM'(1) << (acc_w - 1)) - ACC_W_LIM'(1);
  endfunction

  function automatic logic [ACC_W_LIM-1:0] ACC_MIN(input int acc_w);
    return ACC_W_LIM'(1) << (acc_w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_product_accumulator_if.sv
// ============================================================================
// Module  : booth_product_accumulator_if
// Purpose : Job control, product stream and result stream of the accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface booth_product_accumulator_if
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic              busy;
  logic              overflow;

  modport master (
    output start, len, prod_valid, prod_data, acc_ready,
    input  prod_ready, acc_valid, acc_data, busy, overflow
  );

  modport slave (
    input  start, len, prod_valid, prod_data, acc_ready,
    output prod_ready, acc_valid, acc_data, busy, overflow
  );
endinterface

`default_nettype wire

// File: rtl/booth_acc_adder.sv
// ============================================================================
// Module  : booth_acc_adder
// Purpose : Signed ACC_W adder with overflow flag. BOOTH_ACC_SATURATE_EN
//           clamps the sum on overflow instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_acc_adder
  import booth_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_overflow
);

  logic signed [ACC_W-1:0] w_raw;

`ifdef BOOTH_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] C_MAX = ACC_W'(ACC_MAX(ACC_W));
  localparam logic [ACC_W-1:0] C_MIN = ACC_W'(ACC_MIN(ACC_W));
`endif

  always_comb begin
    w_raw      = i_a + i_b;
    o_overflow = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
`ifdef BOOTH_ACC_SATURATE_EN
    // Both addends share a sign on overflow, so i_a's sign picks the rail.
    o_sum = o_overflow ? (i_a[ACC_W-1] ? C_MIN : C_MAX) : w_raw;
`else
    o_sum = w_raw;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/booth_product_accumulator.sv
// ============================================================================
// Module  : booth_product_accumulator
// Purpose : Sums len signed products and presents the total on a valid/ready
//           output. Optional macro BOOTH_ACC_SATURATE_EN selects saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_product_accumulator
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic                         clk,
  input logic                         reset,
  booth_product_accumulator_if.slave  bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_data_q, acc_data_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    overflow_q, overflow_d;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_add_ovf;
  logic                     w_hs;
  logic                     w_last;

  assign w_prod     = bus.prod_data;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_hs       = bus.prod_valid && (state_q == ACCUM);
  assign w_last     = (count_q + LEN_W'(1)) == len_q;

  booth_acc_adder #(.ACC_W(ACC_W)) u_adder (
    .i_a        (acc_q),
    .i_b        (w_prod_ext),
    .o_sum      (w_sum),
    .o_overflow (w_add_ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_data_d = acc_data_q;
    count_d    = count_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d      = bus.len;
          acc_d      = '0;
          acc_data_d = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = (bus.len == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (w_hs) begin
          acc_d      = w_sum;
          count_d    = count_q + LEN_W'(1);
          overflow_d = overflow_q | w_add_ovf;
          if (w_last) begin
            acc_data_d = w_sum;
            state_d    = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (bus.acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_data_q <= '0;
      count_q    <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_data_q <= acc_data_d;
      count_q    <= count_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.prod_ready = (state_q == ACCUM);
  assign bus.acc_valid  = (state_q == OUTPUT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.acc_data   = acc_data_q;
  assign bus.overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
// ============================================================================
// Module  : tb_booth_product_accumulator
// Purpose : Scoreboard bench for booth_product_accumulator (72-bit and 64-bit
//           accumulator instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_product_accumulator;
  import booth_mac_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  bit          sel;
  logic        tb_start;
  logic [7:0]  tb_len;
  logic        tb_prod_valid;
  logic [63:0] tb_prod_data;
  logic        tb_acc_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [71:0] data;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  logic signed [127:0] m_acc;
  int                  m_w;
  logic                m_ovf;

  booth_product_accumulator_if #(.PROD_W(64), .ACC_W(72), .LEN_W(8)) bus_a ();
  booth_product_accumulator_if #(.PROD_W(64), .ACC_W(64), .LEN_W(8)) bus_b ();

  booth_product_accumulator #(.PROD_W(64), .ACC_W(72), .LEN_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  booth_product_accumulator #(.PROD_W(64), .ACC_W(64), .LEN_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  assign bus_a.start      = tb_start & ~sel;
  assign bus_b.start      = tb_start & sel;
  assign bus_a.len        = tb_len;
  assign bus_b.len        = tb_len;
  assign bus_a.prod_valid = tb_prod_valid & ~sel;
  assign bus_b.prod_valid = tb_prod_valid & sel;
  assign bus_a.prod_data  = tb_prod_data;
  assign bus_b.prod_data  = tb_prod_data;
  assign bus_a.acc_ready  = tb_acc_ready & ~sel;
  assign bus_b.acc_ready  = tb_acc_ready & sel;

  wire        w_prod_ready = sel ? bus_b.prod_ready : bus_a.prod_ready;
  wire        w_acc_valid  = sel ? bus_b.acc_valid  : bus_a.acc_valid;
  wire        w_busy       = sel ? bus_b.busy       : bus_a.busy;
  wire        w_overflow   = sel ? bus_b.overflow   : bus_a.overflow;
  wire [71:0] w_acc_data   = sel ? {{8{bus_b.acc_data[63]}}, bus_b.acc_data} : bus_a.acc_data;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact sum, then wrap or clamp into the accumulator range.
  task automatic m_start(input int w);
    m_acc = '0;
    m_w   = w;
    m_ovf = 1'b0;
  endtask

  task automatic m_add(input logic signed [63:0] p);
    logic signed [127:0] exact, mx, mn;
    int k;
    mx    = (128'sd1 <<< (m_w - 1)) - 128'sd1;
    mn    = -(128'sd1 <<< (m_w - 1));
    exact = m_acc + p;
    k     = 128 - m_w;
    if (exact > mx || exact < mn) begin
      m_ovf = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
      exact = (exact > mx) ? mx : mn;
`else
      exact = (exact <<< k) >>> k;
`endif
    end
    m_acc = exact;
  endtask

  task automatic push_exp();
    exp_t e;
    e.data = m_acc[71:0];
    e.ovf  = m_ovf;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] len);
    tb_start = 1'b1;
    tb_len   = len;
    tick();
    tb_start = 1'b0;
  endtask

  task automatic send(input logic signed [63:0] p);
    logic hs;
    hs            = 1'b0;
    tb_prod_valid = 1'b1;
    tb_prod_data  = p;
    for (int n = 0; n < 50; n++) begin
      hs = w_prod_ready;
      tick();
      if (hs) break;
    end
    tb_prod_valid = 1'b0;
    if (hs) m_add(p);
    else check("prod_timeout", hs, 1'b1);
  endtask

  task automatic drain(input int stall);
    logic [71:0] held;
    logic        ok;
    held = w_acc_data;
    ok   = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("valid_hold", w_acc_valid, 1'b1);
      check("data_hold", w_acc_data, held);
      tick();
    end
    tb_acc_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ok = w_acc_valid;
      tick();
      if (ok) break;
    end
    tb_acc_ready = 1'b0;
    check("out_timeout", ok, 1'b1);
    check("idle_after", w_busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset && w_acc_valid && tb_acc_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("acc_data", w_acc_data, e.data);
        check("overflow", w_overflow, e.ovf);
      end
    end
  end

  initial begin
    reset = 1'b1; sel = 1'b0; tb_start = 1'b0; tb_len = '0;
    tb_prod_valid = 1'b0; tb_prod_data = '0; tb_acc_ready = 1'b0;
    tick(); tick();
    check("rst_prod_ready", w_prod_ready, 1'b0);
    check("rst_acc_valid", w_acc_valid, 1'b0);
    check("rst_acc_data", w_acc_data, 72'd0);
    check("rst_busy", w_busy, 1'b0);
    check("rst_overflow", w_overflow, 1'b0);
    reset = 1'b0;
    tick();

    // Three back-to-back products; result one cycle after the last handshake.
    m_start(72);
    do_start(8'd3);
    check("busy_accum", w_busy, 1'b1);
    send(64'sd2226);
    send(-64'sd35);
    check("valid_early", w_acc_valid, 1'b0);
    send(64'sd48);
    check("latency", w_acc_valid, 1'b1);
    check("sum_2239", w_acc_data, 72'd2239);
    push_exp();
    drain(0);
    tick();

    // Zero-length job.
    m_start(72);
    do_start(8'd0);
    check("len0_valid", w_acc_valid, 1'b1);
    check("len0_ready", w_prod_ready, 1'b0);
    push_exp();
    drain(0);
    tick();

    // Idle product cycles and a stalled sink.
    m_start(72);
    do_start(8'd2);
    send(64'sd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_no_valid", w_acc_valid, 1'b0);
    end
    send(-64'sd7);
    push_exp();
    drain(5);
    tick();

    // Reset in the middle of a job.
    m_start(72);
    do_start(8'd4);
    send(64'sd11);
    send(64'sd22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", w_busy, 1'b0);
    check("mid_rst_ready", w_prod_ready, 1'b0);
    check("mid_rst_data", w_acc_data, 72'd0);
    tick();
    check("mid_rst_valid", w_acc_valid, 1'b0);
    m_start(72);
    do_start(8'd1);
    send(-64'sd1);
    push_exp();
    drain(0);
    tick();

    // Starts while busy are ignored, including during the output handshake.
    m_start(72);
    do_start(8'd2);
    tb_start = 1'b1; tb_len = 8'd5;
    tick();
    tb_start = 1'b0;
    send(64'sd100);
    send(-64'sd30);
    check("ignored_len", w_acc_valid, 1'b1);
    push_exp();
    tb_acc_ready = 1'b1; tb_start = 1'b1; tb_len = 8'd5;
    tick();
    tb_acc_ready = 1'b0; tb_start = 1'b0;
    check("start_in_hs", w_busy, 1'b0);
    tick();
    check("idle_gap", w_busy, 1'b0);

    // Random products with random idle gaps.
    m_start(72);
    do_start(8'd6);
    for (int i = 0; i < 6; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      send({$urandom, $urandom});
    end
    push_exp();
    drain(2);
    tick();

    // 64-bit accumulator: overflow on 2^62 + 2^62, then cleared by next job.
    sel = 1'b1;
    tick();
    m_start(64);
    do_start(8'd2);
    send(64'h4000_0000_0000_0000);
    send(64'h4000_0000_0000_0000);
    check("ovf_set", w_overflow, 1'b1);
    push_exp();
    drain(1);
    tick();
    m_start(64);
    do_start(8'd1);
    check("ovf_cleared", w_overflow, 1'b0);
    send(64'sd5);
    push_exp();
    drain(0);
    tick();

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
